sram_test_engine: RTL and testbench
===================================

SRAM_TEST_ENGINE -- requirements
Module: sram_test_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning SRAM address width (depth = 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8, meaning SRAM data width.
REQ-003 SHALL have parameter RD_LAT, default 1, range 1..3, meaning cycles from read issue (s_cen/s_oen low) to valid s_qdata.
REQ-004 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-high reset (one clock domain, reset sampled on rising clk edge only).
REQ-005 SHALL have ports: cmd_valid in 1 command strobe; cmd_op in 3 opcode; cmd_addr in ADDR_W single-access address; cmd_data in DATA_W write data or test pattern; cmd_ready out 1 equals !busy.
REQ-006 SHALL have ports: busy out 1 operation in progress; done out 1 one-cycle completion pulse; rd_data out DATA_W read result; rd_valid out 1 one-cycle qualifier for rd_data.
REQ-007 SHALL have ports: err_cnt out ADDR_W+1 mismatch count; fail_flag out 1 any mismatch; fail_addr out ADDR_W first mismatching address.
REQ-008 SHALL have ports: s_cen, s_wen, s_oen out 1 each, active-low; s_addr out ADDR_W; s_ddata out DATA_W; s_qdata in DATA_W.

Function
REQ-009 SHALL decode opcodes: 0 NOP, 1 WR_ONE, 2 RD_ONE, 3 FILL, 4 CHECK, 5 MARCH; opcodes 6,7 and NOP SHALL be ignored (no busy, no done).
REQ-010 SHALL accept a command only on a cycle with cmd_valid=1 and busy=0; commands while busy SHALL be dropped, not queued.
REQ-011 SHALL assert busy the cycle after acceptance and deassert it in the same cycle done pulses.
REQ-012 SHALL use FSM states IDLE, WR_SWEEP, RD_SWEEP, MARCH_R, MARCH_W, DRAIN, DONE; DONE lasts exactly one cycle then IDLE.
REQ-013 WR_ONE SHALL drive one write (s_cen=0, s_wen=0, s_oen=1) at cmd_addr with cmd_data, then DONE.
REQ-014 RD_ONE SHALL drive one read (s_cen=0, s_oen=0, s_wen=1) at cmd_addr, wait RD_LAT cycles in DRAIN, present rd_data with rd_valid=1, then DONE.
REQ-015 FILL SHALL write cmd_data to addresses 0..2**ADDR_W-1 ascending, one write per cycle, 2**ADDR_W cycles total.
REQ-016 CHECK SHALL read addresses 0..max ascending, one per cycle, compare each returned word to the latched pattern RD_LAT cycles after issue, and enter DONE after the last compare.
REQ-017 MARCH SHALL run three elements: ascending write P; ascending read-compare P then write ~P per address (2 cycles/address); descending read-compare ~P; P is cmd_data latched at acceptance.
REQ-018 In MARCH read-then-write at one address, the write SHALL be issued only after the read is issued; pipelined compare SHALL still occur RD_LAT cycles after its read.
REQ-019 Address counter SHALL terminate at max (ascending) or 0 (descending) without wrapping into another access.
REQ-020 All SRAM outputs SHALL be registered; when idle s_cen=s_wen=s_oen=1, s_addr and s_ddata hold last value.
REQ-021 Each compare mismatch SHALL increment err_cnt, saturating at all-ones; the first mismatch after command acceptance SHALL set fail_flag and capture fail_addr; later mismatches SHALL not change fail_addr.
REQ-022 err_cnt, fail_flag, fail_addr SHALL clear on acceptance of CHECK or MARCH and hold until the next such command.
REQ-023 rd_valid SHALL pulse for every compared word in CHECK/MARCH with rd_data = returned word.

Reset
REQ-024 reset SHALL, at the next rising clk, force IDLE, busy=0, done=0, rd_valid=0, rd_data=0, err_cnt=0, fail_flag=0, fail_addr=0, s_cen=s_wen=s_oen=1, s_addr=0, s_ddata=0.
REQ-025 reset mid-operation SHALL abort without completing the sweep and without a done pulse.

Configuration
REQ-026 With SRAM_ERRLOG_EN defined, compare, err_cnt, fail_flag, fail_addr SHALL behave per REQ-021/022.
REQ-027 Without SRAM_ERRLOG_EN, err_cnt, fail_flag, fail_addr SHALL be tied 0, compare logic SHALL be absent, and sweeps/rd_valid SHALL behave identically.

Structure
REQ-028 Opcode constants and FSM state encodings SHALL live in shared package sram_test_pkg.
REQ-029 Address sequencing SHALL be sub-module sram_addr_seq (load, up/down step, terminal-count flag, width ADDR_W).

Verification (ADDR_W=4, DATA_W=8, RD_LAT=1, SRAM model)
REQ-030 FILL 0x5A then CHECK 0x5A -> 16 rd_valid pulses each 0x5A, err_cnt=0, fail_flag=0, one done per command.
REQ-031 FILL 0xA5, WR_ONE addr 7 data 0x00, CHECK 0xA5 -> err_cnt=1, fail_flag=1, fail_addr=7.
REQ-032 MARCH 0x00 on fault-free model -> 16 writes 0x00, 16 reads 0x00 interleaved with 16 writes 0xFF, descending reads 0xFF from addr 15 to 0, err_cnt=0.
REQ-033 cmd_valid with opcode 3 while busy, and opcode 6 while idle -> no effect, busy/done unchanged.
REQ-034 reset asserted at sweep address 9 -> next cycle all outputs per REQ-024, no done; RD_ONE afterwards returns correct data after 1 + RD_LAT cycles.
REQ-035 Build without SRAM_ERRLOG_EN, rerun REQ-031 -> err_cnt=0, fail_flag=0, rd_data at addr 7 = 0x00.

Source files
------------

// File: rtl/sram_test_pkg.sv
// Shared opcode, FSM state and march-element encodings for the SRAM test engine.
package sram_test_pkg;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_WR_ONE = 3'd1,
    OP_RD_ONE = 3'd2,
    OP_FILL   = 3'd3,
    OP_CHECK  = 3'd4,
    OP_MARCH  = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SWEEP = 3'd1,
    RD_SWEEP = 3'd2,
    MARCH_R  = 3'd3,
    MARCH_W  = 3'd4,
    DRAIN    = 3'd5,
    DONE     = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    ME_W0  = 2'd0,  // ascending write P
    ME_RW1 = 2'd1,  // ascending read P, write ~P
    ME_R2  = 2'd2   // descending read ~P
  } march_elem_e;

  // Commands whose acceptance restarts the error log.
  function automatic logic starts_errlog(input op_e op);
    return (op == OP_CHECK) || (op == OP_MARCH);
  endfunction

endpackage

// File: rtl/sram_addr_seq.sv
// Loadable up/down address counter with a direction-aware terminal-count flag.
module sram_addr_seq #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              tc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= load_val;
    end else if (step) begin
      addr <= down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  // Terminal count never wraps: the owner stops stepping once tc is seen.
  assign tc = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_test_engine.sv
// Built-in SRAM test engine: single access, fill, check and march sweeps.
// Optional compare/error logging is enabled by defining SRAM_ERRLOG_EN.
module sram_test_engine
  import sram_test_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   err_cnt,
  output logic              fail_flag,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              s_cen,
  output logic              s_wen,
  output logic              s_oen,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_ddata,
  input  logic [DATA_W-1:0] s_qdata
);

  state_e            state;
  march_elem_e       elem;
  logic              single;
  logic              dir_down;
  logic [DATA_W-1:0] pat;
  op_e               op_in;
  logic              accept;
  logic              seq_load;
  logic              seq_step;
  logic [ADDR_W-1:0] seq_val;
  logic              tc;
  logic              rd_act;
  logic [RD_LAT-1:0] pipe_q;
  logic [RD_LAT:0]   tok;

  assign op_in     = op_e'(cmd_op);
  assign accept    = cmd_valid && !busy;
  assign cmd_ready = !busy;

  sram_addr_seq #(.ADDR_W(ADDR_W)) u_addr_seq (
    .clk      (clk),
    .reset    (reset),
    .load     (seq_load),
    .load_val (seq_val),
    .step     (seq_step),
    .down     (dir_down),
    .addr     (s_addr),
    .tc       (tc)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    seq_load = 1'b0;
    seq_step = 1'b0;
    seq_val  = '0;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          case (op_in)
            OP_WR_ONE, OP_RD_ONE: begin
              seq_load = 1'b1;
              seq_val  = cmd_addr;
            end
            OP_FILL, OP_CHECK, OP_MARCH: seq_load = 1'b1;
            default: ;
          endcase
        end
      end
      WR_SWEEP, RD_SWEEP: seq_step = !(single || tc);
      MARCH_W: begin
        if (tc) begin
          seq_load = 1'b1;
          seq_val  = (elem == ME_W0) ? '0 : '1;
        end else begin
          seq_step = 1'b1;
        end
      end
      MARCH_R: seq_step = (elem == ME_R2) && !tc;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      elem     <= ME_W0;
      single   <= 1'b0;
      dir_down <= 1'b0;
      pat      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s_cen    <= 1'b1;
      s_wen    <= 1'b1;
      s_oen    <= 1'b1;
      s_ddata  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          s_cen <= 1'b1;
          s_wen <= 1'b1;
          s_oen <= 1'b1;
          if (accept) begin
            case (op_in)
              OP_WR_ONE, OP_FILL: begin
                state    <= WR_SWEEP;
                single   <= (op_in == OP_WR_ONE);
                dir_down <= 1'b0;
                busy     <= 1'b1;
                pat      <= cmd_data;
                s_ddata  <= cmd_data;
                s_cen    <= 1'b0;
                s_wen    <= 1'b0;
              end
              OP_RD_ONE, OP_CHECK: begin
                state    <= RD_SWEEP;
                single   <= (op_in == OP_RD_ONE);
                dir_down <= 1'b0;
                busy     <= 1'b1;
                pat      <= cmd_data;
                s_cen    <= 1'b0;
                s_oen    <= 1'b0;
              end
              OP_MARCH: begin
                state    <= MARCH_W;
                elem     <= ME_W0;
                single   <= 1'b0;
                dir_down <= 1'b0;
                busy     <= 1'b1;
                pat      <= cmd_data;
                s_ddata  <= cmd_data;
                s_cen    <= 1'b0;
                s_wen    <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        WR_SWEEP: begin
          if (single || tc) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            s_cen <= 1'b1;
            s_wen <= 1'b1;
          end
        end
        RD_SWEEP: begin
          if (single || tc) begin
            state <= DRAIN;
            s_cen <= 1'b1;
            s_oen <= 1'b1;
          end
        end
        MARCH_W: begin
          // Element 0 keeps writing until its last address; element 1 always goes back to a read.
          if (elem != ME_W0 || tc) begin
            state <= MARCH_R;
            s_cen <= 1'b0;
            s_wen <= 1'b1;
            s_oen <= 1'b0;
            if (elem == ME_W0) begin
              elem <= ME_RW1;
            end else if (tc) begin
              elem     <= ME_R2;
              dir_down <= 1'b1;
            end
          end
        end
        MARCH_R: begin
          if (elem == ME_RW1) begin
            state   <= MARCH_W;
            s_cen   <= 1'b0;
            s_oen   <= 1'b1;
            s_wen   <= 1'b0;
            s_ddata <= ~pat;
          end else if (tc) begin
            state <= DRAIN;
            s_cen <= 1'b1;
            s_oen <= 1'b1;
          end
        end
        DRAIN: begin
          if (tok[RD_LAT-1:0] == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // tok[i] marks a read issued i cycles ago; tok[RD_LAT] means s_qdata is valid now.
  assign rd_act = !s_cen && !s_oen;
  assign tok    = {pipe_q, rd_act};

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      pipe_q   <= tok[RD_LAT-1:0];
      rd_valid <= tok[RD_LAT];
      if (tok[RD_LAT]) rd_data <= s_qdata;
    end
  end

`ifdef SRAM_ERRLOG_EN
  logic                           cmp_cur;
  logic [DATA_W-1:0]              exp_cur;
  logic [RD_LAT-1:0]              cmp_pipe;
  logic [RD_LAT-1:0][DATA_W-1:0]  exp_pipe;
  logic [RD_LAT-1:0][ADDR_W-1:0]  addr_pipe;
  logic                           mismatch;

  assign cmp_cur = rd_act && ((state == RD_SWEEP && !single) || state == MARCH_R);
  assign exp_cur = (elem == ME_R2) ? ~pat : pat;

  always_ff @(posedge clk) begin
    if (reset) cmp_pipe <= '0;
    else       cmp_pipe <= {cmp_pipe, cmp_cur};
  end

  // NOTE: data/address pipes carry no reset; they are only consulted when cmp_pipe qualifies them.
  always_ff @(posedge clk) begin
    exp_pipe[0]  <= exp_cur;
    addr_pipe[0] <= s_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      exp_pipe[i]  <= exp_pipe[i-1];
      addr_pipe[i] <= addr_pipe[i-1];
    end
  end

  assign mismatch = cmp_pipe[RD_LAT-1] && (s_qdata != exp_pipe[RD_LAT-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt   <= '0;
      fail_flag <= 1'b0;
      fail_addr <= '0;
    end else if (accept && starts_errlog(op_in)) begin
      err_cnt   <= '0;
      fail_flag <= 1'b0;
      fail_addr <= '0;
    end else if (mismatch) begin
      if (err_cnt != '1) err_cnt <= err_cnt + (ADDR_W+1)'(1);
      if (!fail_flag) begin
        fail_flag <= 1'b1;
        fail_addr <= addr_pipe[RD_LAT-1];
      end
    end
  end
`else
  assign err_cnt   = '0;
  assign fail_flag = 1'b0;
  assign fail_addr = '0;
`endif

endmodule

// File: tb/tb_sram_test_engine.sv
// Self-checking bench for sram_test_engine (ADDR_W=4, DATA_W=8, RD_LAT=1) with an SRAM model.
module tb_sram_test_engine;
  import sram_test_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int RD_LAT = 1;
  localparam int DEPTH = 1 << AW;
`ifdef SRAM_ERRLOG_EN
  localparam bit ERRLOG = 1'b1;
`else
  localparam bit ERRLOG = 1'b0;
`endif

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready, busy, done, rd_valid;
  logic [DW-1:0] rd_data;
  logic [AW:0]   err_cnt;
  logic          fail_flag;
  logic [AW-1:0] fail_addr;
  logic          s_cen, s_wen, s_oen;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_ddata, s_qdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_test_engine #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .err_cnt(err_cnt), .fail_flag(fail_flag), .fail_addr(fail_addr),
    .s_cen(s_cen), .s_wen(s_wen), .s_oen(s_oen), .s_addr(s_addr),
    .s_ddata(s_ddata), .s_qdata(s_qdata)
  );

  // SRAM model: synchronous write, read data appears RD_LAT cycles after issue.
  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] q_pipe [RD_LAT];
  always @(posedge clk) begin
    if (!s_cen && !s_wen) mem[s_addr] <= s_ddata;
    q_pipe[0] <= mem[s_addr];
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign s_qdata = q_pipe[RD_LAT-1];

  // Monitor, sampled mid-cycle.
  ev_t           ev_q[$];
  logic [DW-1:0] rd_q[$];
  int            done_cnt;
  always @(negedge clk) begin
    if (!reset) begin
      if (!s_cen && !s_wen)      ev_q.push_back('{wr: 1'b1, addr: s_addr, data: s_ddata});
      else if (!s_cen && !s_oen) ev_q.push_back('{wr: 1'b0, addr: s_addr, data: '0});
      if (rd_valid) rd_q.push_back(rd_data);
      if (done) done_cnt++;
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH];
  ev_t           exp_ev[$];
  logic [DW-1:0] exp_rd[$];
  int            exp_err   = 0;
  bit            exp_fail  = 1'b0;
  int            exp_faddr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_rdv"},   rd_valid, 0);
    check({tag, "_rdd"},   rd_data, 0);
    check({tag, "_err"},   err_cnt, 0);
    check({tag, "_fail"},  fail_flag, 0);
    check({tag, "_faddr"}, fail_addr, 0);
    check({tag, "_ctl"},   {s_cen, s_wen, s_oen}, 3'b111);
    check({tag, "_addr"},  s_addr, 0);
    check({tag, "_ddata"}, s_ddata, 0);
    check({tag, "_ready"}, cmd_ready, 1);
  endtask

  task automatic log_read(input int a, input logic [DW-1:0] expv);
    exp_ev.push_back('{wr: 1'b0, addr: AW'(a), data: '0});
    exp_rd.push_back(ref_mem[a]);
    if (ref_mem[a] !== expv) begin
      if (exp_err < 31) exp_err++;
      if (!exp_fail) begin
        exp_fail  = 1'b1;
        exp_faddr = a;
      end
    end
  endtask

  task automatic log_write(input int a, input logic [DW-1:0] d);
    exp_ev.push_back('{wr: 1'b1, addr: AW'(a), data: d});
    ref_mem[a] = d;
  endtask

  // Expected SRAM traffic, read results and error log from the command's definition.
  task automatic build_exp(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_ev.delete();
    exp_rd.delete();
    if (op == OP_CHECK || op == OP_MARCH) begin
      exp_err = 0; exp_fail = 1'b0; exp_faddr = 0;
    end
    case (op)
      OP_WR_ONE: log_write(a, d);
      OP_RD_ONE: begin
        exp_ev.push_back('{wr: 1'b0, addr: a, data: '0});
        exp_rd.push_back(ref_mem[a]);
      end
      OP_FILL:  for (int i = 0; i < DEPTH; i++) log_write(i, d);
      OP_CHECK: for (int i = 0; i < DEPTH; i++) log_read(i, d);
      OP_MARCH: begin
        for (int i = 0; i < DEPTH; i++) log_write(i, d);
        for (int i = 0; i < DEPTH; i++) begin
          log_read(i, d);
          log_write(i, ~d);
        end
        for (int i = DEPTH - 1; i >= 0; i--) log_read(i, ~d);
      end
      default: ;
    endcase
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int inj);
    int lat, busy_n, bad_ev, bad_rd;
    logic rdv_at_done;
    build_exp(op, a, d);
    ev_q.delete();
    rd_q.delete();
    done_cnt = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = -1; busy_n = 0; rdv_at_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_after_accept", busy, 1);
      if (i == inj) begin
        check("ready_while_busy", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_addr = '0; cmd_data = ~d;
      end
      if (i == inj + 1) cmd_valid = 1'b0;
      if (done) begin
        lat = i + 1;
        rdv_at_done = rd_valid;
        break;
      end
      if (busy) busy_n++;
    end
    cmd_valid = 1'b0;
    check("cmd_timeout", lat > 0, 1);
    repeat (2) @(negedge clk);
    bad_ev = -1;
    for (int i = 0; i < ev_q.size() && i < exp_ev.size(); i++)
      if (bad_ev < 0 && ev_q[i] !== exp_ev[i]) bad_ev = i;
    bad_rd = -1;
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++)
      if (bad_rd < 0 && rd_q[i] !== exp_rd[i]) bad_rd = i;
    check("sram_ev_count", ev_q.size(), exp_ev.size());
    check("sram_ev_first_bad", bad_ev, -1);
    check("rd_count", rd_q.size(), exp_rd.size());
    check("rd_first_bad", bad_rd, -1);
    check("done_count", done_cnt, 1);
    check("busy_after_done", busy, 0);
    check("err_cnt", err_cnt, ERRLOG ? exp_err : 0);
    check("fail_flag", fail_flag, ERRLOG ? exp_fail : 0);
    check("fail_addr", fail_addr, ERRLOG ? exp_faddr : 0);
    if (op == OP_FILL) check("fill_busy_cycles", busy_n, DEPTH);
    if (op == OP_RD_ONE) begin
      check("rd_one_latency", lat, RD_LAT + 2);
      check("rd_one_valid_at_done", rdv_at_done, 1);
    end
  endtask

  initial begin
    logic [2:0]    ign_ops [3];
    logic [2:0]    rnd_ops [5];
    logic [DW-1:0] p;
    bit            saw_busy, found;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    reset = 1'b0;

    // Fill/check, single-word fault, march on a clean array.
    do_cmd(OP_FILL, '0, 8'h5A, -1);
    do_cmd(OP_CHECK, '0, 8'h5A, -1);
    do_cmd(OP_FILL, '0, 8'hA5, -1);
    do_cmd(OP_WR_ONE, 4'd7, 8'h00, -1);
    do_cmd(OP_CHECK, '0, 8'hA5, -1);
    do_cmd(OP_RD_ONE, 4'd7, 8'h00, -1);
    do_cmd(OP_MARCH, '0, 8'h00, -1);

    // Command while busy is dropped; ignored opcodes while idle do nothing.
    do_cmd(OP_FILL, '0, 8'h3C, 4);
    ign_ops = '{3'd0, 3'd6, 3'd7};
    foreach (ign_ops[k]) begin
      ev_q.delete();
      done_cnt = 0;
      saw_busy = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = ign_ops[k]; cmd_data = 8'hFF;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        if (busy) saw_busy = 1'b1;
      end
      check("ignored_busy", saw_busy, 0);
      check("ignored_done", done_cnt, 0);
      check("ignored_sram", ev_q.size(), 0);
    end

    // Reset in the middle of a fill sweep at address 9.
    p = 8'($urandom);
    done_cnt = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_FILL; cmd_data = p;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!s_cen && s_addr == 4'd9) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_addr9", found, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", done_cnt, 0);
    for (int i = 0; i <= 9; i++) ref_mem[i] = p;
    exp_err = 0; exp_fail = 1'b0; exp_faddr = 0;
    do_cmd(OP_RD_ONE, 4'($urandom_range(0, 9)), '0, -1);

    // Randomized command mix against the reference model.
    rnd_ops = '{OP_WR_ONE, OP_RD_ONE, OP_FILL, OP_CHECK, OP_MARCH};
    p = 8'($urandom);
    do_cmd(OP_FILL, '0, p, -1);
    for (int n = 0; n < 14; n++) begin
      logic [2:0] op;
      logic [DW-1:0] d;
      op = rnd_ops[$urandom_range(0, 4)];
      d  = ($urandom_range(0, 1) == 0) ? p : 8'($urandom);
      if (op == OP_FILL || op == OP_MARCH) p = (op == OP_MARCH) ? ~d : d;
      do_cmd(op, 4'($urandom), d, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
